// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_pkg
// Brief    : Shared constants, FSM state types and checksum helper for the
//            player-state UART frame scheduler.
// Revision : 1.0
// ============================================================================
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } tx_state_t;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        B1   = 3'd1,
        B2   = 3'd2,
        B3   = 3'd3,
        CHK  = 3'd4
    } rx_state_t;

    function automatic logic [7:0] frame_chk(
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return b1 ^ b2 ^ b3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_rx
// Brief    : Frame parser for the player-state link: sync hunt, checksum,
//            byte timeout, link-alive timer and atomic remote-state update.
// Revision : 1.0
// ============================================================================
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 200000,
    parameter int LINK_TIMEOUT = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_rd,
    output logic [11:0] remote_x,
    output logic [11:0] remote_y,
    output logic [1:0]  remote_level,
    output logic        remote_valid,
    output logic        frame_err
);

    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int LT_W = $clog2(LINK_TIMEOUT + 1);
    localparam logic [BT_W-1:0] c_byte_last = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [LT_W-1:0] c_link_last = LT_W'(LINK_TIMEOUT - 1);

    rx_state_t       r_state;
    rx_state_t       w_state_nxt;
    logic            r_en;
    logic [BT_W-1:0] r_byte_cnt;
    logic [LT_W-1:0] r_link_cnt;
    logic [7:0]      r_b1;
    logic [7:0]      r_b2;
    logic [7:0]      r_b3;
    logic            w_pop;
    logic            w_in_frame;
    logic            w_byte_to;
    logic            w_good;
    logic            w_bad;
    logic            w_chk_ok;

    // r_en keeps the FIFO untouched while reset is (or was just) asserted
    assign w_pop      = r_en & ~rx_empty;
    assign w_in_frame = (r_state != HUNT);
    assign w_byte_to  = w_in_frame & ~w_pop & (r_byte_cnt == c_byte_last);
    assign w_chk_ok   = (rx_data == frame_chk(r_b1, r_b2, r_b3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HUNT: if (w_pop && (rx_data == SYNC_BYTE)) w_state_nxt = B1;
            B1:   if (w_pop) w_state_nxt = B2; else if (w_byte_to) w_state_nxt = HUNT;
            B2:   if (w_pop) w_state_nxt = B3; else if (w_byte_to) w_state_nxt = HUNT;
            B3:   if (w_pop) w_state_nxt = CHK; else if (w_byte_to) w_state_nxt = HUNT;
            CHK:  if (w_pop || w_byte_to) w_state_nxt = HUNT;
            default: w_state_nxt = HUNT;
        endcase
    end

    always_comb begin
        rx_rd  = w_pop;
        w_good = 1'b0;
        w_bad  = w_byte_to;
        if ((r_state == CHK) && w_pop) begin
            w_good = w_chk_ok;
            w_bad  = ~w_chk_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en         <= 1'b0;
            r_byte_cnt   <= '0;
            r_link_cnt   <= '0;
            r_b1         <= '0;
            r_b2         <= '0;
            r_b3         <= '0;
            remote_x     <= '0;
            remote_y     <= '0;
            remote_level <= '0;
            remote_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            r_en      <= 1'b1;
            frame_err <= w_bad;

            if (!w_in_frame || w_pop) begin
                r_byte_cnt <= '0;
            end else if (r_byte_cnt != c_byte_last) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            if (w_pop) begin
                case (r_state)
                    B1:      r_b1 <= rx_data;
                    B2:      r_b2 <= rx_data;
                    B3:      r_b3 <= rx_data;
                    default: ;
                endcase
            end

            // All three remote fields change on the same edge
            if (w_good) begin
                remote_x     <= {1'b0, r_b2[2:0], r_b1};
                remote_y     <= {1'b0, r_b3[5:0], r_b2[7:3]};
                remote_level <= r_b3[7:6];
                remote_valid <= 1'b1;
                r_link_cnt   <= '0;
            end else if (remote_valid) begin
                if (r_link_cnt == c_link_last) begin
                    remote_valid <= 1'b0;
                end else begin
                    r_link_cnt <= r_link_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_sched
// Brief    : Periodic TX of the local player-state frame and RX of the remote
//            one over a single UART FIFO pair. UART_FRAME_STATS_EN enables the
//            err_cnt/drop_cnt counters (tied to 0 otherwise).
// Revision : 1.0
// ============================================================================
module uart_frame_sched
    import uart_frame_pkg::*;
#(
    parameter int FRAME_PERIOD = 1666667,
    parameter int BYTE_TIMEOUT = 200000,
    parameter int LINK_TIMEOUT = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic [1:0]  level,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_rd,
    output logic [11:0] remote_x,
    output logic [11:0] remote_y,
    output logic [1:0]  remote_level,
    output logic        remote_valid,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic [7:0]  drop_cnt
);

    localparam int TK_W = $clog2(FRAME_PERIOD + 1);
    localparam logic [TK_W-1:0] c_tick_last = TK_W'(FRAME_PERIOD - 1);
    localparam logic [2:0]      c_idx_last  = 3'(FRAME_LEN - 1);

    logic [TK_W-1:0] r_tick_cnt;
    logic            w_tick;
    tx_state_t       r_tx_state;
    tx_state_t       w_tx_state_nxt;
    logic [2:0]      r_idx;
    logic [7:0]      r_tb1;
    logic [7:0]      r_tb2;
    logic [7:0]      r_tb3;
    logic [7:0]      r_tb4;
    logic [7:0]      w_b1;
    logic [7:0]      w_b2;
    logic [7:0]      w_b3;
    logic            w_drop;
    logic            w_unused_msb;

    assign w_unused_msb = x_pos[11] ^ y_pos[11];

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_b1 = x_pos[7:0];
    assign w_b2 = {y_pos[4:0], x_pos[10:8]};
    assign w_b3 = {level, y_pos[10:5]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= IDLE;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            IDLE:    if (w_tick) w_tx_state_nxt = LOAD;
            LOAD:    w_tx_state_nxt = SEND;
            SEND:    if (!tx_full && (r_idx == c_idx_last)) w_tx_state_nxt = IDLE;
            default: w_tx_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_wr   = 1'b0;
        tx_data = 8'h00;
        w_drop  = w_tick && (r_tx_state != IDLE);
        if (r_tx_state == SEND) begin
            tx_wr = ~tx_full;
            case (r_idx)
                3'd0:    tx_data = SYNC_BYTE;
                3'd1:    tx_data = r_tb1;
                3'd2:    tx_data = r_tb2;
                3'd3:    tx_data = r_tb3;
                default: tx_data = r_tb4;
            endcase
        end
    end

    // Snapshot in LOAD so input changes cannot tear a frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_tb1 <= '0;
            r_tb2 <= '0;
            r_tb3 <= '0;
            r_tb4 <= '0;
        end else if (r_tx_state == LOAD) begin
            r_idx <= '0;
            r_tb1 <= w_b1;
            r_tb2 <= w_b2;
            r_tb3 <= w_b3;
            r_tb4 <= frame_chk(w_b1, w_b2, w_b3);
        end else if (tx_wr) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    uart_frame_rx #(
        .BYTE_TIMEOUT (BYTE_TIMEOUT),
        .LINK_TIMEOUT (LINK_TIMEOUT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_rd        (rx_rd),
        .remote_x     (remote_x),
        .remote_y     (remote_y),
        .remote_level (remote_level),
        .remote_valid (remote_valid),
        .frame_err    (frame_err)
    );

`ifdef UART_FRAME_STATS_EN
    logic [7:0] r_err_cnt;
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (frame_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign err_cnt  = r_err_cnt;
    assign drop_cnt = r_drop_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_drop;
    assign err_cnt        = 8'h00;
    assign drop_cnt       = 8'h00;
`endif

endmodule
`default_nettype wire
